// File: rtl/slink_crc_pkg.sv
// slink_crc_pkg: shared state encoding and CRC-16/MCRF44X helpers for the slink CRC path
package slink_crc_pkg;
   typedef enum logic [1:0] {IDLE, PAYLOAD, CRC_LO, CRC_HI} state_t;
   localparam logic [15:0] CRC_INIT      = 16'hFFFF;
   localparam logic [15:0] CRC_POLY_REFL = 16'h8408;
   function automatic logic [15:0] crc16_mcrf_byte(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc ^ {8'h00, data};
      for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ CRC_POLY_REFL : c >> 1;
      return c;
   endfunction
endpackage

// File: rtl/slink_crc_8_16bit_compute.sv
// slink_crc_8_16bit_compute: one-byte CRC-16/MCRF44X step with seed load and hold
module slink_crc_8_16bit_compute #(
   parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
   input  logic [15:0] crc_prev,
   input  logic [7:0]  data,
   input  logic        valid,
   input  logic        init,
   output logic [15:0] crc_next
);
   logic [7:0] data_c;
`ifndef SYNTHESIS
   // unknown payload bits count as 0 so an X never sticks in the running CRC
   always_comb begin
      for (int i = 0; i < 8; i++) data_c[i] = data[i] === 1'b1;
   end
`else
   assign data_c = data;
`endif
   assign crc_next = init ? CRC_INIT : valid ? slink_crc_pkg::crc16_mcrf_byte(crc_prev, data_c) : crc_prev;
endmodule

// File: rtl/slink_crc_gen_ctrl.sv
// slink_crc_gen_ctrl: passes a counted payload through and appends its CRC-16 (low byte first)
module slink_crc_gen_ctrl #(
   parameter int          WC_WIDTH = 16,
   parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   output logic                start_ready,
   input  logic [WC_WIDTH-1:0] wc,
   input  logic                abort,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [7:0]          in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [7:0]          out_data,
   output logic                out_last,
   output logic                done,
   output logic [15:0]         crc_last,
   output logic                busy
);
   import slink_crc_pkg::state_t;
   import slink_crc_pkg::IDLE;
   import slink_crc_pkg::PAYLOAD;
   import slink_crc_pkg::CRC_LO;
   import slink_crc_pkg::CRC_HI;
   state_t state;
   logic [WC_WIDTH-1:0] bytes_left;
   logic [15:0] crc, crc_next;
   logic xfer;
   assign start_ready = state == IDLE;
   assign busy        = state != IDLE;
   assign in_ready    = state == PAYLOAD && out_ready;
   assign out_valid   = state == PAYLOAD ? in_valid : state != IDLE;
   assign out_data    = state == PAYLOAD ? in_data : state == CRC_LO ? crc[7:0] : state == CRC_HI ? crc[15:8] : 8'h00;
   assign out_last    = state == CRC_HI;
   assign xfer        = state == PAYLOAD && in_valid && out_ready && bytes_left != '0;
   // init wins over valid, so a byte handshaked alongside abort never reaches the CRC
   slink_crc_8_16bit_compute #(.CRC_INIT(CRC_INIT)) u_crc (
      .crc_prev (crc),
      .data     (in_data),
      .valid    (xfer),
      .init     (abort || (start && start_ready)),
      .crc_next (crc_next)
   );
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         crc        <= CRC_INIT;
         bytes_left <= '0;
         crc_last   <= '0;
         done       <= 1'b0;
      end else begin
         crc  <= crc_next;
         done <= 1'b0;
         if (abort) begin
            state      <= IDLE;
            bytes_left <= '0;
         end else begin
            case (state)
               IDLE: if (start) begin
                  bytes_left <= wc;
                  state      <= wc != '0 ? PAYLOAD : CRC_LO;
               end
               PAYLOAD: if (xfer) begin
                  bytes_left <= bytes_left - 1'b1;
                  if (bytes_left == WC_WIDTH'(1)) state <= CRC_LO;
               end
               CRC_LO: if (out_ready) state <= CRC_HI;
               CRC_HI: if (out_ready) begin
                  crc_last <= crc;
                  done     <= 1'b1;
                  state    <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_slink_crc_gen_ctrl.sv
// tb_slink_crc_gen_ctrl: directed and randomized packet checks against a bit-serial CRC model
module tb_slink_crc_gen_ctrl;
   typedef logic [7:0] bq_t[$];
   logic clk = 1'b0;
   logic reset_n, start, start_ready, abort, in_valid, in_ready, out_valid, out_ready, out_last, done, busy;
   logic [15:0] wc, crc_last, prev_crc_last;
   logic [7:0] in_data, out_data;
   int tests = 0, fails = 0;
   bq_t pl, got, vec;

   slink_crc_gen_ctrl dut (
      .clk(clk), .reset_n(reset_n), .start(start), .start_ready(start_ready), .wc(wc),
      .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .done(done), .crc_last(crc_last), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   // MSB-first CRC with the unreflected polynomial on bit-reversed data, reversed at the end
   function automatic logic [15:0] model_crc(input bq_t b);
      logic [15:0] r, o;
      r = 16'hFFFF;
      foreach (b[j])
         for (int k = 0; k < 8; k++) begin
            if (r[15] ^ b[j][k]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else r = {r[14:0], 1'b0};
         end
      for (int k = 0; k < 16; k++) o[k] = r[15-k];
      return o;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input int n, input bit stall, input int ab, input bit pre, input bit nxt, input int nxt_wc);
      int idx, busy_n;
      bit fin, hold, have_prev, iv;
      logic [7:0] prev_d;
      logic [15:0] exp_crc;
      exp_crc = model_crc(pl);
      got.delete();
      idx = 0; busy_n = 0; fin = 0; hold = 0; have_prev = 0; iv = 0; prev_d = 8'h00;
      if (!pre) begin
         @(posedge clk); #1;
         start = 1'b1; wc = 16'(n);
         @(negedge clk);
      end
      chk("start_ready", start_ready, 1);
      for (int c = 0; c < 4000 && !fin; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (!hold) iv = idx < n && (!stall || $urandom_range(1) == 1);
         in_valid = iv;
         in_data = idx < n ? pl[idx] : 8'($urandom);
         out_ready = !stall || $urandom_range(1) == 1;
         abort = ab >= 0 && idx == ab;
         @(negedge clk);
         if (busy) busy_n++;
         if (abort) fin = 1;
         else begin
            if (idx < n) chk("in_ready_eq_out_ready", in_ready, out_ready);
            if (have_prev) chk("out_data_stable", out_data, prev_d);
            have_prev = out_valid && !out_ready;
            prev_d = out_data;
            hold = in_valid && !in_ready;
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
               got.push_back(out_data);
               if (out_last) fin = 1;
            end
         end
      end
      @(posedge clk); #1;
      abort = 1'b0; in_valid = 1'b0; start = nxt; wc = 16'(nxt_wc);
      @(negedge clk);
      if (ab >= 0) begin
         chk("abort_len", got.size(), ab);
         chk("abort_done", done, 0);
         chk("abort_crc_last", crc_last, prev_crc_last);
         chk("abort_idle", start_ready, 1);
         chk("abort_out_valid", out_valid, 0);
      end else begin
         chk("len", got.size(), n + 2);
         for (int i = 0; i < n && i < got.size(); i++) chk("payload", got[i], pl[i]);
         if (got.size() == n + 2) begin
            chk("crc_lo", got[n], exp_crc[7:0]);
            chk("crc_hi", got[n+1], exp_crc[15:8]);
         end
         chk("done", done, 1);
         chk("crc_last", crc_last, exp_crc);
         chk("idle_after", busy, 0);
         prev_crc_last = exp_crc;
         if (n == 0 && !stall) chk("busy_cycles", busy_n, 2);
         if (!nxt) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("done_pulse", done, 0);
         end
      end
   endtask

   initial begin
      vec = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h1E, 8'hF0, 8'h1E, 8'hC7, 8'h4F, 8'h82, 8'h78, 8'hC5,
              8'h82, 8'hE0, 8'h8C, 8'h70, 8'hD2, 8'h3C, 8'h78, 8'hE9, 8'hFF, 8'h00, 8'h00, 8'h01};
      reset_n = 1'b0; start = 1'b0; wc = '0; abort = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      prev_crc_last = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_start_ready", start_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_crc_last", crc_last, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      pl = vec;
      send(24, 0, -1, 0, 0, 0);
      chk("vec_crc", crc_last, 16'hE569);
      pl = {};
      send(0, 0, -1, 0, 0, 0);
      chk("wc0_crc", crc_last, 16'hFFFF);
      pl = vec;
      repeat (3) begin
         send(24, 1, -1, 0, 0, 0);
         chk("stall_vec_crc", crc_last, 16'hE569);
      end
      send(24, 0, 10, 0, 0, 0);
      send(24, 0, -1, 0, 0, 0);
      chk("post_abort_crc", crc_last, 16'hE569);
      send(24, 0, -1, 0, 1, 1);
      pl = '{8'h00};
      send(1, 0, -1, 1, 0, 0);
      @(posedge clk); #1;
      start = 1'b1; wc = '0; out_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("crc_lo_held", out_valid, 1);
      reset_n = 1'b0;
      #1;
      chk("midrst_start_ready", start_ready, 1);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_last", out_last, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_crc_last", crc_last, 0);
      prev_crc_last = '0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_rst_start_ready", start_ready, 1);
      for (int k = 0; k < 6; k++) begin
         pl = {};
         for (int i = 0, n = $urandom_range(40, 1); i < n; i++) pl.push_back(8'($urandom));
         send(pl.size(), 1, -1, 0, 0, 0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
